matrix_sequencer: RTL and testbench

Multicycle instruction sequencer for the matrix datapath. It accepts one decoded 27-bit instruction at a time from the instruction-memory path over a valid/ready handshake. It then drives the data-memory read strobe, the functional-unit enable for each unit's configured latency, and the write-back strobe, and finally signals retirement so the program counter may advance. It replaces fixed single-cycle enable decoding with latency-aware sequencing of add_sub, matrix_mult, scale_matrix and transpose.

---
 rtl/matrix_seq_pkg.sv | 56 +++++
 rtl/seq_lat_counter.sv | 34 +++
 rtl/matrix_sequencer.sv | 168 ++++++++++++++++
 tb/tb_matrix_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_seq_pkg.sv
// Shared definitions for the matrix instruction sequencer.
// Holds the opcode values, the bit positions of the instruction fields,
// the sequencer state type and a helper that clamps a configured unit
// latency into the 4-bit counter range.
// Used by the instruction-memory path, the sequencer and its bench.
package matrix_seq_pkg;

  localparam int INSTR_W  = 27;
  localparam int OPCODE_W = 5;
  localparam int ADDR_W   = 7;
  localparam int SCALAR_W = 8;
  localparam int LAT_W    = 4;

  // Field positions inside the 27-bit instruction word.
  // scalar overlaps src2; the unit that runs decides which view it uses.
  localparam int OPC_MSB    = 26;
  localparam int OPC_LSB    = 22;
  localparam int DEST_MSB   = 21;
  localparam int DEST_LSB   = 15;
  localparam int SRC1_MSB   = 14;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 7;
  localparam int SRC2_LSB   = 1;
  localparam int SCALAR_MSB = 7;
  localparam int SCALAR_LSB = 0;

  localparam logic [OPCODE_W-1:0] OP_NOP       = 5'h00;
  localparam logic [OPCODE_W-1:0] OP_ADD       = 5'h01;
  localparam logic [OPCODE_W-1:0] OP_SUB       = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_MULT      = 5'h03;
  localparam logic [OPCODE_W-1:0] OP_SCALE     = 5'h04;
  localparam logic [OPCODE_W-1:0] OP_TRANSPOSE = 5'h05;
  localparam logic [OPCODE_W-1:0] OP_HALT      = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // A latency of 0 would never reach the last-cycle flag, so it runs as 1.
  function automatic logic [LAT_W-1:0] eff_lat(input int unsigned lat);
    if (lat == 0)       return 4'd1;
    else if (lat > 15)  return 4'd15;
    else                return LAT_W'(lat);
  endfunction

  // Opcodes that walk through READ / EXEC / WRITE.
  function automatic logic is_unit_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULT) ||
           (op == OP_SCALE) || (op == OP_TRANSPOSE);
  endfunction

endpackage

// File: rtl/seq_lat_counter.sv
// Loadable 4-bit down-counter that times how long a functional-unit enable
// stays high.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : load load_val this edge (has priority over en)
//   en          : decrement this edge (holds at 0)
//   load_val    : latency to load
//   count       : current value
//   last        : count == 1, i.e. this is the final enable cycle
module seq_lat_counter
  import matrix_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/matrix_sequencer.sv
// Multicycle sequencer for the matrix datapath.
// Accepts one decoded instruction over a valid/ready handshake and walks it
// through READ (data-memory read strobe), EXEC (unit enable held for the
// unit's latency) and WRITE (write-back strobe plus retire pulse).
// NOP and illegal opcodes retire one cycle after accept without leaving IDLE;
// HALT parks the sequencer until reset.
//
// Handshake: an instruction is consumed on a rising edge where instr_valid
// and instr_ready are both high; the word must stay stable until then, and
// instr_ready is only high in IDLE.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   instr_valid, instr_word        instruction in; instr_ready back
//   r_reg, w_reg                   data-memory read / write-back strobes
//   enable_add/mult/scale/transpose functional-unit enables
//   add_or_sub                     1 = subtract while enable_add is high
//   dest_addr, src1_addr, src2_addr, scalar_out  fields latched at accept
//   done                           one-cycle retire pulse
//   halted, err                    HALT executed / sticky illegal opcode
//   perf_retired, perf_busy        saturating counters, only present when
//                                  MATRIX_SEQ_PERF_EN is defined
module matrix_sequencer
  import matrix_seq_pkg::*;
#(
  parameter int MULT_LAT  = 4,
  parameter int ADD_LAT   = 1,
  parameter int SCALE_LAT = 1,
  parameter int TRANS_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr_word,
  output logic                instr_ready,
  output logic                r_reg,
  output logic                w_reg,
  output logic                enable_add,
  output logic                enable_mult,
  output logic                enable_scale,
  output logic                enable_transpose,
  output logic                add_or_sub,
  output logic [ADDR_W-1:0]   dest_addr,
  output logic [ADDR_W-1:0]   src1_addr,
  output logic [ADDR_W-1:0]   src2_addr,
  output logic [SCALAR_W-1:0] scalar_out,
  output logic                done,
  output logic                halted,
`ifdef MATRIX_SEQ_PERF_EN
  output logic [15:0]         perf_retired,
  output logic [15:0]         perf_busy,
`endif
  output logic                err
);

  state_t                state;
  state_t                next_state;
  logic [OPCODE_W-1:0]   op_q;
  logic                  quick_done_q;
  logic                  accept;
  logic [OPCODE_W-1:0]   op_in;
  logic [LAT_W-1:0]      unit_lat;
  logic [LAT_W-1:0]      lat_count;
  logic                  lat_last;
  logic                  op_legal;

  assign accept   = instr_valid && instr_ready;
  assign op_in    = instr_word[OPC_MSB:OPC_LSB];
  assign op_legal = is_unit_op(op_in) || (op_in == OP_NOP) || (op_in == OP_HALT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_unit_op(op_in))      next_state = ST_READ;
          else if (op_in == OP_HALT)  next_state = ST_HALT;
        end
      end
      ST_READ:  next_state = ST_EXEC;
      ST_EXEC:  if (lat_last) next_state = ST_WRITE;
      ST_WRITE: next_state = ST_IDLE;
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched opcode.
  always_comb begin
    instr_ready      = (state == ST_IDLE);
    r_reg            = (state == ST_READ);
    w_reg            = (state == ST_WRITE);
    enable_add       = (state == ST_EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB));
    enable_mult      = (state == ST_EXEC) && (op_q == OP_MULT);
    enable_scale     = (state == ST_EXEC) && (op_q == OP_SCALE);
    enable_transpose = (state == ST_EXEC) && (op_q == OP_TRANSPOSE);
    add_or_sub       = enable_add && (op_q == OP_SUB);
    done             = (state == ST_WRITE) || quick_done_q;
    halted           = (state == ST_HALT);
  end

  // Fields latched at accept; they persist until the next accept.
  // quick_done_q gives NOP/illegal their retire pulse in the cycle after
  // accept while the FSM stays in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= OP_NOP;
      dest_addr    <= '0;
      src1_addr    <= '0;
      src2_addr    <= '0;
      scalar_out   <= '0;
      quick_done_q <= 1'b0;
      err          <= 1'b0;
    end else begin
      quick_done_q <= accept && !is_unit_op(op_in) && (op_in != OP_HALT);
      if (accept) begin
        op_q       <= op_in;
        dest_addr  <= instr_word[DEST_MSB:DEST_LSB];
        src1_addr  <= instr_word[SRC1_MSB:SRC1_LSB];
        src2_addr  <= instr_word[SRC2_MSB:SRC2_LSB];
        scalar_out <= instr_word[SCALAR_MSB:SCALAR_LSB];
        if (!op_legal) err <= 1'b1;
      end
    end
  end

  always_comb begin
    case (op_q)
      OP_MULT:      unit_lat = eff_lat(MULT_LAT);
      OP_SCALE:     unit_lat = eff_lat(SCALE_LAT);
      OP_TRANSPOSE: unit_lat = eff_lat(TRANS_LAT);
      default:      unit_lat = eff_lat(ADD_LAT);
    endcase
  end

  // Loaded during READ so the first EXEC cycle sees the full latency.
  seq_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_READ),
    .en       (state == ST_EXEC),
    .load_val (unit_lat),
    .count    (lat_count),
    .last     (lat_last)
  );

`ifdef MATRIX_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_retired <= '0;
      perf_busy    <= '0;
    end else begin
      if (done && (perf_retired != 16'hFFFF))
        perf_retired <= perf_retired + 16'd1;
      if ((state inside {ST_READ, ST_EXEC, ST_WRITE}) && (perf_busy != 16'hFFFF))
        perf_busy <= perf_busy + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_sequencer.sv
module tb_matrix_sequencer;
  import matrix_seq_pkg::*;

  localparam int P_MULT  = 4;
  localparam int P_ADD   = 1;
  localparam int P_SCALE = 3;
  localparam int P_TRANS = 2;
  localparam int EW      = 39;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [26:0] instr_word;
  logic        instr_ready, r_reg, w_reg;
  logic        enable_add, enable_mult, enable_scale, enable_transpose;
  logic        add_or_sub, done, halted, err;
  logic [6:0]  dest_addr, src1_addr, src2_addr;
  logic [7:0]  scalar_out;
`ifdef MATRIX_SEQ_PERF_EN
  logic [15:0] perf_retired, perf_busy;
`endif

  always #5 clk = ~clk;

  matrix_sequencer #(
    .MULT_LAT(P_MULT), .ADD_LAT(P_ADD), .SCALE_LAT(P_SCALE), .TRANS_LAT(P_TRANS)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_word(instr_word),
    .instr_ready(instr_ready), .r_reg(r_reg), .w_reg(w_reg),
    .enable_add(enable_add), .enable_mult(enable_mult), .enable_scale(enable_scale),
    .enable_transpose(enable_transpose), .add_or_sub(add_or_sub),
    .dest_addr(dest_addr), .src1_addr(src1_addr), .src2_addr(src2_addr),
    .scalar_out(scalar_out), .done(done), .halted(halted),
`ifdef MATRIX_SEQ_PERF_EN
    .perf_retired(perf_retired), .perf_busy(perf_busy),
`endif
    .err(err)
  );

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- scoreboard state ----------------
  // record: {sub, unit_mask[3:0], done_offset[4:0], scalar, src2, src1, dest}
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            total = 0;
  int            bad   = 0;
  bit            halted_m = 0;
  bit            err_m    = 0;
  int            exp_retired = 0;
  int            exp_busy    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] mk(input logic [4:0] op, input logic [6:0] d,
                                     input logic [6:0] s1, input logic [7:0] low8);
    return {op, d, s1, low8};
  endfunction

  // Reference model: what one accepted word should produce.
  task automatic model_accept(input logic [26:0] w);
    logic [4:0] op;
    logic [3:0] mask;
    logic       sub;
    int         lat;
    int         off;
    op = w[26:22]; mask = 4'b0; sub = 1'b0; lat = 0;
    case (op)
      5'h00: ;
      5'h01: begin mask = 4'b0001; lat = P_ADD; end
      5'h02: begin mask = 4'b0001; lat = P_ADD; sub = 1'b1; end
      5'h03: begin mask = 4'b0010; lat = P_MULT; end
      5'h04: begin mask = 4'b0100; lat = P_SCALE; end
      5'h05: begin mask = 4'b1000; lat = P_TRANS; end
      5'h1F: begin halted_m = 1; return; end
      default: err_m = 1;
    endcase
    off = (mask != 0) ? lat + 2 : 1;
    exp_q.push_back({sub, mask, 5'(off), w[7:0], w[7:1], w[14:8], w[21:15]});
    acc_q.push_back(cyc_cnt);
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [26:0] w);
    int guard;
    bit got;
    instr_valid = 1'b1;
    instr_word  = w;
    got = 0; guard = 0;
    while (!got && guard < 200) begin
      @(negedge clk);
      got = instr_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!got) check("accept_timeout", 0, 1);
    else      model_accept(w);
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush_model();
    exp_q.delete(); acc_q.delete();
    halted_m = 0; err_m = 0; exp_retired = 0; exp_busy = 0;
  endtask

  // ---------------- monitor ----------------
  int         r_cnt, r_off, w_cnt, w_off, en_cnt, en_first, sub_bad, off, exp_off;
  logic [3:0] en_mask, en_now;
  logic [EW-1:0] e;
  bit         run_mon = 0;
  bit         busy_exp, long_op;

  always @(negedge clk) begin
    if (reset) begin
      r_cnt = 0; w_cnt = 0; en_cnt = 0; en_mask = 0; sub_bad = 0;
      r_off = 0; w_off = 0; en_first = 0;
    end else if (run_mon) begin
      en_now = {enable_transpose, enable_scale, enable_mult, enable_add};
      check("strobe_onehot", ($countones({r_reg, w_reg, en_now}) <= 1), 1);
      check("halted", halted, halted_m);
      check("err", err, err_m);
      busy_exp = 0; off = 0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        off = cyc_cnt - acc_q[0] + 1;
        exp_off = int'(e[33:29]);
        long_op = (e[37:34] != 0);
        busy_exp = long_op && (off >= 1) && (off <= exp_off);
        if (r_reg) begin r_cnt++; r_off = off; end
        if (w_reg) begin w_cnt++; w_off = off; end
        if (en_now != 0) begin
          if (en_cnt == 0) en_first = off;
          en_cnt++;
          en_mask |= en_now;
        end
        if (enable_add && (add_or_sub !== e[38])) sub_bad++;
      end else begin
        check("stray_strobe", {r_reg, w_reg, en_now, done}, 0);
      end
      check("instr_ready", instr_ready, !halted_m && !busy_exp);
      if (done && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        check("done_offset", off, exp_off);
        check("r_reg_count", r_cnt, long_op ? 1 : 0);
        check("w_reg_count", w_cnt, long_op ? 1 : 0);
        check("unit_mask", en_mask, e[37:34]);
        check("enable_cycles", en_cnt, long_op ? exp_off - 2 : 0);
        if (long_op) begin
          check("r_reg_offset", r_off, 1);
          check("enable_first", en_first, 2);
          check("w_reg_offset", w_off, exp_off);
        end
        check("add_or_sub", sub_bad, 0);
        check("dest_addr", dest_addr, e[6:0]);
        check("src1_addr", src1_addr, e[13:7]);
        check("src2_addr", src2_addr, e[20:14]);
        check("scalar_out", scalar_out, e[28:21]);
        exp_retired++;
        if (long_op) exp_busy += exp_off;
        r_cnt = 0; w_cnt = 0; en_cnt = 0; en_mask = 0; sub_bad = 0;
        r_off = 0; w_off = 0; en_first = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] op;
    int         k;
    int         guard;
    reset = 1'b1; instr_valid = 1'b0; instr_word = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_reg", r_reg, 0);
    check("rst_w_reg", w_reg, 0);
    check("rst_enables", {enable_add, enable_mult, enable_scale, enable_transpose}, 0);
    check("rst_done", done, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_addrs", {dest_addr, src1_addr, src2_addr, scalar_out}, 0);
    #2 reset = 1'b0;
    run_mon = 1;
    idle(1);

    // Directed: ADD, MULT then SUB back to back, illegal then NOP.
    issue(mk(OP_ADD, 7'h10, 7'h01, {7'h02, 1'b0}));
    issue(mk(OP_MULT, 7'h22, 7'h33, 8'h5A));
    issue(mk(OP_SUB, 7'h44, 7'h05, 8'h0C));
    issue(mk(5'h07, 7'h01, 7'h02, 8'h03));
    issue(mk(OP_NOP, 7'h11, 7'h12, 8'h13));
    idle(2);

    // Randomized mix with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: op = OP_ADD;
        2:    op = OP_SUB;
        3:    op = OP_MULT;
        4:    op = OP_SCALE;
        5:    op = OP_TRANSPOSE;
        6, 7: op = OP_NOP;
        default: op = 5'($urandom_range(6, 30));
      endcase
      issue(mk(op, 7'($urandom), 7'($urandom), 8'($urandom)));
      idle($urandom_range(0, 2));
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin idle(1); guard++; end
    check("drain_random", exp_q.size(), 0);
`ifdef MATRIX_SEQ_PERF_EN
    check("perf_retired", perf_retired, exp_retired);
    check("perf_busy", perf_busy, exp_busy);
`endif

    // HALT, then a valid ADD that must never be consumed.
    issue(mk(OP_HALT, 7'h6B, 7'h2C, 8'hE1));
    instr_valid = 1'b1;
    instr_word  = mk(OP_ADD, 7'h01, 7'h01, 8'h01);
    idle(8);
    check("halt_dest_held", dest_addr, 7'h6B);
    check("halt_scalar_held", scalar_out, 8'hE1);
    instr_valid = 1'b0;
    reset = 1'b1;
    flush_model();
    #1;
    check("halt_cleared", halted, 0);
    @(posedge clk); #3 reset = 1'b0;
    idle(1);

    // Reset in the second EXEC cycle of MULT aborts it.
    issue(mk(OP_MULT, 7'h0A, 7'h0B, 8'h0C));
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mult_exec2", enable_mult, 1);
    reset = 1'b1;
    #1;
    check("abort_enable_mult", enable_mult, 0);
    check("abort_done", done, 0);
    check("abort_w_reg", w_reg, 0);
    flush_model();
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    check("ready_after_abort", instr_ready, 1);
    idle(6);

    // Short closing sequence for the optional counters.
    issue(mk(OP_ADD, 7'h01, 7'h02, 8'h03));
    issue(mk(OP_NOP, 7'h00, 7'h00, 8'h00));
    issue(mk(OP_MULT, 7'h04, 7'h05, 8'h06));
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin idle(1); guard++; end
    check("drain_final", exp_q.size(), 0);
    idle(2);
`ifdef MATRIX_SEQ_PERF_EN
    check("perf_retired_final", perf_retired, 3);
    check("perf_busy_final", perf_busy, 9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
